// File: rtl/obi_sram_shim.sv
// rtl/obi_sram_shim.sv - OBI subordinate endpoint bridging to a single-port SRAM with 1-cycle read latency

package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
        bit          UseRReady;
        bit          Integrity;
        bit          UseAtop;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32, DataWidth: 32, IdWidth: 4,
        UseRReady: 1'b1, Integrity: 1'b0, UseAtop: 1'b0
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_sram_shim #(
    parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t     = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t     = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumMaxTrans   = 2,
    parameter longint unsigned   BaseAddr      = 0,
    parameter int unsigned       SramAddrWidth = 10,
    localparam int unsigned      DataWidth     = ObiCfg.DataWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  obi_req_t                 obi_req_i,
    output obi_rsp_t                 obi_rsp_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [DataWidth/8-1:0]   sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
);
    localparam int unsigned AW       = ObiCfg.AddrWidth;
    localparam int unsigned IW       = ObiCfg.IdWidth;
    localparam int unsigned ByteBits = $clog2(DataWidth / 8);
    localparam int unsigned CntW     = $clog2(NumMaxTrans + 1);
    localparam int unsigned PtrW     = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam logic [AW-1:0]   BaseA   = AW'(BaseAddr);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(NumMaxTrans);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NumMaxTrans - 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IW-1:0]        rid;
        logic                 err;
    } entry_t;

    logic [AW-1:0]       offset;
    logic [ByteBits-1:0] unused_offset;
    logic                in_range, gnt, sram_hit, rvalid, r_hs;
    logic [CntW-1:0]     cnt, fcnt;
    logic                pend_valid, pend_err, pend_we;
    logic [IW-1:0]       pend_aid;
    entry_t              pend_entry, head;
    entry_t              fifo_mem [NumMaxTrans];
    logic [PtrW-1:0]     wptr, rptr;
    logic                fifo_empty, fifo_full, push, pop_fifo;

    // Offset is modular; addresses below the base wrap and are also rejected explicitly.
    assign offset        = obi_req_i.a.addr - BaseA;
    assign unused_offset = offset[ByteBits-1:0];
    assign in_range      = (obi_req_i.a.addr >= BaseA) &&
                           (offset[AW-1:ByteBits+SramAddrWidth] == '0);

    assign gnt      = obi_req_i.req && (cnt < MaxCnt) && rst_ni;
    assign sram_hit = gnt && in_range;

    assign sram_req_o   = sram_hit;
    assign sram_we_o    = sram_hit && obi_req_i.a.we;
    assign sram_addr_o  = sram_hit ? offset[ByteBits +: SramAddrWidth] : '0;
    assign sram_wdata_o = sram_hit ? obi_req_i.a.wdata : '0;
    assign sram_be_o    = sram_hit ? obi_req_i.a.be : '0;

    assign fifo_empty = (fcnt == '0);
    assign fifo_full  = (fcnt == MaxCnt);
    assign rvalid     = !fifo_empty || pend_valid;
    assign r_hs       = rvalid && obi_req_i.rready;
    assign pop_fifo   = r_hs && !fifo_empty;
    // The pending entry skips the FIFO when it is presented and consumed in the same cycle.
    assign push       = pend_valid && !(fifo_empty && r_hs);

    always_comb begin
        pend_entry     = '0;
        pend_entry.rid = pend_aid;
        pend_entry.err = pend_err;
        if (!pend_err && !pend_we) begin
            pend_entry.rdata = sram_rdata_i;
        end
    end

    assign head = fifo_empty ? pend_entry : fifo_mem[rptr];

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid;
        if (rvalid) begin
            obi_rsp_o.r.rdata = head.rdata;
            obi_rsp_o.r.rid   = head.rid;
            obi_rsp_o.r.err   = head.err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt        <= '0;
            fcnt       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            pend_we    <= 1'b0;
            pend_aid   <= '0;
        end else begin
            if (gnt && !r_hs) begin
                cnt <= cnt + CntW'(1);
            end else if (!gnt && r_hs) begin
                cnt <= cnt - CntW'(1);
            end
            pend_valid <= gnt;
            pend_err   <= gnt && !in_range;
            pend_we    <= gnt && obi_req_i.a.we;
            pend_aid   <= gnt ? obi_req_i.a.aid : '0;
            if (push) begin
                wptr <= (wptr == LastIdx) ? '0 : wptr + PtrW'(1);
            end
            if (pop_fifo) begin
                rptr <= (rptr == LastIdx) ? '0 : rptr + PtrW'(1);
            end
            if (push && !pop_fifo) begin
                fcnt <= fcnt + CntW'(1);
            end else if (!push && pop_fifo) begin
                fcnt <= fcnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wptr] <= pend_entry;
        end
    end

    // The credit counter bounds outstanding entries, so a push into a full FIFO is a design bug.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_obi_sram_shim.sv
// tb/tb_obi_sram_shim.sv - scoreboard bench for obi_sram_shim with behavioural SRAM model

module tb_obi_sram_shim;
    localparam longint unsigned BASE = 64'h1000;

    logic               clk = 1'b0;
    logic               rst_n;
    obi_pkg::obi_req_t  obi_req;
    obi_pkg::obi_rsp_t  obi_rsp;
    logic               sram_req, sram_we;
    logic [9:0]         sram_addr;
    logic [31:0]        sram_wdata, sram_rdata;
    logic [3:0]         sram_be;

    obi_sram_shim #(
        .NumMaxTrans  (2),
        .BaseAddr     (BASE),
        .SramAddrWidth(10)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic [3:0] rid, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.rid   = rid;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Monitor: every R handshake pops one expected response in order.
    always @(negedge clk) begin
        if (rst_n && obi_rsp.rvalid && obi_req.rready) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", obi_rsp.rvalid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rid", obi_rsp.r.rid, mon_e.rid);
                check("rsp_rdata", obi_rsp.r.rdata, mon_e.rdata);
                check("rsp_err", obi_rsp.r.err, mon_e.err);
            end
        end
    end

    // Called just after a posedge; returns just after the handshake posedge.
    task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [3:0] aid, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [9:0] exp_saddr);
        int waited = 0;
        obi_req.req     = 1'b1;
        obi_req.a.addr  = addr;
        obi_req.a.we    = we;
        obi_req.a.wdata = wdata;
        obi_req.a.be    = be;
        obi_req.a.aid   = aid;
        forever begin
            @(negedge clk);
            if (obi_rsp.gnt) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            check("gnt_timeout", obi_rsp.gnt, 1'b1);
        end else begin
            check("sram_req", sram_req, !exp_err);
            check("sram_addr", sram_addr, exp_saddr);
            check("sram_we", sram_we, exp_err ? 1'b0 : we);
            if (we) check("sram_wdata", sram_wdata, exp_err ? 32'h0 : wdata);
            push_exp(exp_rdata, aid, exp_err);
        end
        @(posedge clk) #1;
        obi_req.req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk) #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic [31:0] s_addr [4] = '{32'h1010, 32'h1FFC, 32'h1014, 32'h1013};
    logic [31:0] s_data [4] = '{32'hDEAD_BEEF, 32'h1234_ABCD, 32'h5555_AAAA, 32'hDEAD_BEEF};
    int grants;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h004] = 32'hDEAD_BEEF;
        mem[10'h005] = 32'h5555_AAAA;
        mem[10'h3FF] = 32'h1234_ABCD;
        sram_rdata   = 32'h0;
        obi_req      = '0;
        rst_n        = 1'b0;

        // Reset state, with req asserted to show gnt is masked by reset
        obi_req.req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", obi_rsp.gnt, 1'b0);
        check("rst_rvalid", obi_rsp.rvalid, 1'b0);
        check("rst_r", obi_rsp.r, '0);
        check("rst_sram", {sram_req, sram_we, sram_addr, sram_wdata, sram_be}, '0);
        @(posedge clk) #1;
        rst_n           = 1'b1;
        obi_req.req     = 1'b0;
        obi_req.rready  = 1'b1;

        // Single read with one-cycle response latency
        xact(32'h1010, 1'b0, 32'h0, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 10'h004);
        @(negedge clk);
        check("read_latency_rvalid", obi_rsp.rvalid, 1'b1);
        @(posedge clk) #1;

        // Write then read, plus a partial-byte write
        xact(32'h1100, 1'b1, 32'hF0F0_ABAB, 4'hF, 4'd1, 32'h0, 1'b0, 10'h040);
        xact(32'h1100, 1'b0, 32'h0, 4'hF, 4'd2, 32'hF0F0_ABAB, 1'b0, 10'h040);
        xact(32'h1102, 1'b1, 32'h1234_5678, 4'h3, 4'd4, 32'h0, 1'b0, 10'h040);
        xact(32'h1100, 1'b0, 32'h0, 4'hF, 4'd6, 32'hF0F0_5678, 1'b0, 10'h040);
        drain("wr_rd_drain");

        // Out-of-range accesses: above the window, below the base, and a write
        xact(32'h2000, 1'b0, 32'h0, 4'hF, 4'd5, 32'h0, 1'b1, 10'h000);
        xact(32'h0FFC, 1'b0, 32'h0, 4'hF, 4'd6, 32'h0, 1'b1, 10'h000);
        xact(32'h2000, 1'b1, 32'hCAFE_F00D, 4'hF, 4'd7, 32'h0, 1'b1, 10'h000);
        xact(32'h1FFC, 1'b0, 32'h0, 4'hF, 4'd9, 32'h1234_ABCD, 1'b0, 10'h3FF);
        drain("oor_drain");

        // Sustained back-to-back reads
        for (int i = 0; i < 4; i++) begin
            obi_req.req    = 1'b1;
            obi_req.a.addr = s_addr[i];
            obi_req.a.we   = 1'b0;
            obi_req.a.be   = 4'hF;
            obi_req.a.aid  = 4'(i + 12);
            @(negedge clk);
            check("stream_gnt", obi_rsp.gnt, 1'b1);
            if (obi_rsp.gnt) push_exp(s_data[i], 4'(i + 12), 1'b0);
            @(posedge clk) #1;
        end
        obi_req.req = 1'b0;
        drain("stream_drain");

        // Back-pressure: two grants then stall; release pops while full, grant follows a cycle later
        obi_req.rready = 1'b0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = 32'h1010;
        obi_req.a.we   = 1'b0;
        obi_req.a.aid  = 4'd8;
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_gnt", obi_rsp.gnt, (c < 2));
            if (obi_rsp.gnt) begin
                push_exp(32'hDEAD_BEEF, obi_req.a.aid, 1'b0);
                grants++;
            end
            if (c >= 2) begin
                check("bp_hold_rid", obi_rsp.r.rid, 4'd8);
                check("bp_hold_rdata", obi_rsp.r.rdata, 32'hDEAD_BEEF);
            end
            @(posedge clk) #1;
            if (obi_rsp.gnt) obi_req.a.aid = obi_req.a.aid + 4'd1;
        end
        check("bp_grants", grants, 2);
        obi_req.a.aid  = 4'd10;
        obi_req.rready = 1'b1;
        @(negedge clk);
        check("full_pop_gnt", obi_rsp.gnt, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk) #1;
            @(negedge clk);
            check("after_full_gnt", obi_rsp.gnt, 1'b1);
            if (obi_rsp.gnt) push_exp(32'hDEAD_BEEF, obi_req.a.aid, 1'b0);
            @(posedge clk) #1;
            obi_req.a.aid = 4'd11;
            obi_req.req   = (i == 0);
            if (i == 0) begin
                @(negedge clk);
                check("after_full_gnt2", obi_rsp.gnt, 1'b1);
                if (obi_rsp.gnt) push_exp(32'hDEAD_BEEF, 4'd11, 1'b0);
                @(posedge clk) #1;
                obi_req.req = 1'b0;
                break;
            end
        end
        drain("bp_drain");

        // Reset mid-stream with two responses pending
        obi_req.rready = 1'b0;
        xact(32'h1010, 1'b0, 32'h0, 4'hF, 4'd1, 32'hDEAD_BEEF, 1'b0, 10'h004);
        xact(32'h1010, 1'b0, 32'h0, 4'hF, 4'd2, 32'hDEAD_BEEF, 1'b0, 10'h004);
        @(negedge clk);
        check("pre_rst_rvalid", obi_rsp.rvalid, 1'b1);
        @(posedge clk) #2;
        obi_req.req = 1'b1;
        rst_n       = 1'b0;
        #1;
        check("midrst_rvalid", obi_rsp.rvalid, 1'b0);
        check("midrst_gnt", obi_rsp.gnt, 1'b0);
        check("midrst_r", obi_rsp.r, '0);
        check("midrst_sram", {sram_req, sram_we, sram_addr, sram_wdata, sram_be}, '0);
        exp_q.delete();
        @(posedge clk) #1;
        rst_n          = 1'b1;
        obi_req.rready = 1'b1;
        xact(32'h1014, 1'b0, 32'h0, 4'hF, 4'd7, 32'h5555_AAAA, 1'b0, 10'h005);
        drain("post_rst_drain");
        repeat (4) @(posedge clk);
        #1 check("final_rvalid", obi_rsp.rvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
